// File: rtl/scalar_mult_ctrl_if.sv
// Handshake bundle between the scalar-multiply sequencer, the key shift stage
// and the point-arithmetic unit.
interface scalar_mult_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             i_start;
    logic             i_k_bit;
    logic             o_bit_req;
    logic             i_bit_ack;
    logic             o_op_valid;
    logic [1:0]       o_op_code;
    logic             i_op_done;
    logic [CNT_W-1:0] o_bit_idx;
    logic             o_busy;
    logic             o_done;
    logic             o_zero_result;

    // Environment side: starts operations, serves scalar bits and point ops.
    modport master (
        output i_start, i_k_bit, i_bit_ack, i_op_done,
        input  o_bit_req, o_op_valid, o_op_code, o_bit_idx, o_busy, o_done, o_zero_result
    );

    modport slave (
        input  i_start, i_k_bit, i_bit_ack, i_op_done,
        output o_bit_req, o_op_valid, o_op_code, o_bit_idx, o_busy, o_done, o_zero_result
    );
endinterface

// File: rtl/scalar_mult_ctrl.sv
// LSB-first double-and-add sequencer: walks the scalar one bit at a time and
// issues COPY/ADD/DOUBLE commands to an external point-arithmetic unit.
module scalar_mult_ctrl #(
    parameter int KEY_BITS = 32,
    parameter int CNT_W    = 6
) (
    input logic              i_clk,
    input logic              i_rst,
    scalar_mult_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, SAMPLE, ISSUE_A, WAIT_A, ISSUE_D, WAIT_D, REQ, WAIT_ACK, FINISH
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_COPY   = 2'b01,
        OP_ADD    = 2'b10,
        OP_DOUBLE = 2'b11
    } op_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_BITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_idx_q;
    logic             acc_loaded_q;
    logic             zero_q;
    logic             last_bit;
    op_t              op_code;

    assign last_bit = (bit_idx_q == LAST_IDX);

    // NOTE: every variable in a combinational block gets a default before the
    // case statement, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (bus.i_start) state_d = SAMPLE;
            SAMPLE: begin
                if (bus.i_k_bit)   state_d = ISSUE_A;
                else if (last_bit) state_d = FINISH;
                else               state_d = ISSUE_D;
            end
            ISSUE_A:  state_d = WAIT_A;
            WAIT_A:   if (bus.i_op_done) state_d = last_bit ? FINISH : ISSUE_D;
            ISSUE_D:  state_d = WAIT_D;
            WAIT_D:   if (bus.i_op_done) state_d = REQ;
            REQ:      state_d = WAIT_ACK;
            WAIT_ACK: if (bus.i_bit_ack) state_d = SAMPLE;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            acc_loaded_q <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.i_start) begin
                bit_idx_q    <= '0;
                acc_loaded_q <= 1'b0;
                zero_q       <= 1'b0;
            end
            if (state_q == ISSUE_A)
                acc_loaded_q <= 1'b1;
            if (state_q == WAIT_ACK && bus.i_bit_ack)
                bit_idx_q <= bit_idx_q + CNT_W'(1);
            // Latched on entry to FINISH so it is valid alongside o_done.
            if (state_d == FINISH)
                zero_q <= ~acc_loaded_q;
        end
    end

    always_comb begin
        op_code = OP_NONE;
        if (state_q == ISSUE_A)      op_code = acc_loaded_q ? OP_ADD : OP_COPY;
        else if (state_q == ISSUE_D) op_code = OP_DOUBLE;
    end

    assign bus.o_op_valid    = (state_q == ISSUE_A) || (state_q == ISSUE_D);
    assign bus.o_op_code     = op_code;
    assign bus.o_bit_req     = (state_q == REQ);
    assign bus.o_done        = (state_q == FINISH);
    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_bit_idx     = bit_idx_q;
    assign bus.o_zero_result = zero_q;
endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Directed bench for scalar_mult_ctrl: models the key shift stage and a
// fixed-latency point unit, and checks every command against a reference list.
module tb_scalar_mult_ctrl;
    localparam int KEY_BITS = 32;
    localparam int CNT_W    = 6;
    localparam logic [1:0] C_COPY = 2'b01;
    localparam logic [1:0] C_ADD  = 2'b10;
    localparam logic [1:0] C_DBL  = 2'b11;

    typedef struct packed {
        logic [1:0] code;
        logic [31:0] idx;
    } cmd_t;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    scalar_mult_ctrl_if #(.CNT_W(CNT_W)) bus ();

    scalar_mult_ctrl #(.KEY_BITS(KEY_BITS), .CNT_W(CNT_W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    int          n_copy, n_add, n_dbl, n_req;
    bit          done_seen;
    logic        zero_at_done;
    int          done_cyc, last_done_cyc;
    logic [1:0]  last_code;
    logic [31:0] last_idx;
    bit          aborted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     32'(bus.o_busy), 32'd0);
        check({tag, "_done"},     32'(bus.o_done), 32'd0);
        check({tag, "_op_valid"}, 32'(bus.o_op_valid), 32'd0);
        check({tag, "_op_code"},  32'(bus.o_op_code), 32'd0);
        check({tag, "_bit_req"},  32'(bus.o_bit_req), 32'd0);
        check({tag, "_bit_idx"},  32'(bus.o_bit_idx), 32'd0);
        check({tag, "_zero"},     32'(bus.o_zero_result), 32'd0);
    endtask

    // One full operation. spurious=1 injects ignored start/done/ack pulses;
    // abort_idx>=0 asserts reset in WAIT_D of that bit and returns early.
    task automatic run_op(input logic [31:0] k, input int lat, input bit spurious, input int abort_idx);
        cmd_t exp_q[$];
        cmd_t e;
        bit   loaded      = 1'b0;
        int   countdown   = 0;
        bit   ack_pending = 1'b0;
        bit   inject_ack  = 1'b0;
        int   kidx        = 0;

        for (int i = 0; i < KEY_BITS; i++) begin
            if (k[i]) begin
                exp_q.push_back('{code: (loaded ? C_ADD : C_COPY), idx: 32'(i)});
                loaded = 1'b1;
            end
            if (i < KEY_BITS - 1)
                exp_q.push_back('{code: C_DBL, idx: 32'(i)});
        end
        n_copy = 0; n_add = 0; n_dbl = 0; n_req = 0;
        done_seen = 1'b0; zero_at_done = 1'bx; done_cyc = -1; last_done_cyc = -100;
        last_code = 2'b00; last_idx = '0; aborted = 1'b0;

        // The key shift stage is reset between operations.
        @(negedge i_clk) i_rst = 1'b1;
        @(negedge i_clk) i_rst = 1'b0;
        bus.i_k_bit = k[0];

        if (spurious) begin
            bus.i_op_done = 1'b1;
            @(negedge i_clk) bus.i_op_done = 1'b0;
            check("idle_ignores_done", 32'(bus.o_busy), 32'd0);
        end

        bus.i_start = 1'b1;
        @(negedge i_clk) bus.i_start = 1'b0;
        check("busy_after_start", 32'(bus.o_busy), 32'd1);

        for (int cyc = 0; cyc < 2000; cyc++) begin
            bus.i_op_done = 1'b0;
            bus.i_bit_ack = 1'b0;
            bus.i_start   = 1'b0;
            if (bus.o_done) begin
                done_seen    = 1'b1;
                zero_at_done = bus.o_zero_result;
                done_cyc     = cyc;
                break;
            end
            if (bus.o_op_valid) begin
                if (exp_q.size() == 0) begin
                    check("cmd_extra", 32'(bus.o_op_code), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_code", 32'(bus.o_op_code), 32'(e.code));
                    check("cmd_idx", 32'(bus.o_bit_idx), e.idx);
                end
                case (bus.o_op_code)
                    C_COPY:  n_copy++;
                    C_ADD:   n_add++;
                    C_DBL:   n_dbl++;
                    default: ;
                endcase
                last_code = bus.o_op_code;
                last_idx  = 32'(bus.o_bit_idx);
                countdown = lat;
                if (spurious) begin
                    // Done in the issue cycle and a mid-run start must both be ignored.
                    bus.i_op_done = 1'b1;
                    bus.i_start   = 1'b1;
                    inject_ack    = (bus.o_op_code == C_DBL);
                end
            end else if (countdown > 0) begin
                if (abort_idx >= 0 && last_code == C_DBL && last_idx == 32'(abort_idx)) begin
                    i_rst         = 1'b1;
                    bus.i_op_done = 1'b1;
                    aborted       = 1'b1;
                    return;
                end
                countdown--;
                if (countdown == 0) begin
                    bus.i_op_done = 1'b1;
                    last_done_cyc = cyc;
                end else if (inject_ack) begin
                    bus.i_bit_ack = 1'b1;
                    inject_ack    = 1'b0;
                end
            end
            if (bus.o_bit_req) begin
                n_req++;
                ack_pending = 1'b1;
            end else if (ack_pending) begin
                ack_pending   = 1'b0;
                kidx++;
                bus.i_bit_ack = 1'b1;
                bus.i_k_bit   = k[kidx];
            end
            @(negedge i_clk);
        end

        check("done_seen", 32'(done_seen), 32'd1);
        if (done_seen) begin
            check("cmds_left", 32'(exp_q.size()), 32'd0);
            @(negedge i_clk);
            check("busy_fall", 32'(bus.o_busy), 32'd0);
            check("done_one_cycle", 32'(bus.o_done), 32'd0);
            check("zero_held", 32'(bus.o_zero_result), 32'(zero_at_done));
        end
    endtask

    initial begin
        i_rst         = 1'b1;
        bus.i_start   = 1'b0;
        bus.i_k_bit   = 1'b0;
        bus.i_bit_ack = 1'b0;
        bus.i_op_done = 1'b0;

        @(negedge i_clk);
        check_all_zero("reset");
        i_rst = 1'b0;
        @(negedge i_clk);
        check_all_zero("post_reset");

        // k = 0: only doubles and bit requests, zero result flagged.
        run_op(32'h0000_0000, 2, 1'b0, -1);
        check("k0_copy", 32'(n_copy), 32'd0);
        check("k0_add",  32'(n_add),  32'd0);
        check("k0_dbl",  32'(n_dbl),  32'd31);
        check("k0_req",  32'(n_req),  32'd31);
        check("k0_zero", 32'(zero_at_done), 32'd1);

        // k = 1: COPY at bit 0, last command is DOUBLE of bit 30.
        run_op(32'h0000_0001, 1, 1'b0, -1);
        check("k1_copy", 32'(n_copy), 32'd1);
        check("k1_add",  32'(n_add),  32'd0);
        check("k1_dbl",  32'(n_dbl),  32'd31);
        check("k1_req",  32'(n_req),  32'd31);
        check("k1_zero", 32'(zero_at_done), 32'd0);
        check("k1_last_code", 32'(last_code), 32'(C_DBL));
        check("k1_last_idx",  last_idx, 32'd30);

        // k = 0x80000001: ADD at bit 31, done one cycle after its op_done.
        run_op(32'h8000_0001, 3, 1'b0, -1);
        check("kmsb_copy", 32'(n_copy), 32'd1);
        check("kmsb_add",  32'(n_add),  32'd1);
        check("kmsb_dbl",  32'(n_dbl),  32'd31);
        check("kmsb_last_code", 32'(last_code), 32'(C_ADD));
        check("kmsb_last_idx",  last_idx, 32'd31);
        check("kmsb_done_lat",  32'(done_cyc), 32'(last_done_cyc + 1));
        check("kmsb_zero", 32'(zero_at_done), 32'd0);

        // All ones: alternation is enforced by the per-command reference list.
        run_op(32'hFFFF_FFFF, 1, 1'b0, -1);
        check("kff_copy", 32'(n_copy), 32'd1);
        check("kff_add",  32'(n_add),  32'd31);
        check("kff_dbl",  32'(n_dbl),  32'd31);
        check("kff_req",  32'(n_req),  32'd31);

        // Reset in WAIT_D of bit 10 with op_done pending.
        run_op(32'h1234_5678, 2, 1'b0, 10);
        check("abort_reached", 32'(aborted), 32'd1);
        @(negedge i_clk);
        check_all_zero("abort");
        i_rst         = 1'b0;
        bus.i_op_done = 1'b1;
        @(negedge i_clk);
        bus.i_op_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort_no_done", 32'(bus.o_done), 32'd0);
            check("abort_idle",    32'(bus.o_busy), 32'd0);
            @(negedge i_clk);
        end

        // Spurious start/done/ack pulses must not alter the command stream.
        run_op(32'h0000_00A5, 2, 1'b1, -1);
        check("spur_copy", 32'(n_copy), 32'd1);
        check("spur_add",  32'(n_add),  32'd3);
        check("spur_dbl",  32'(n_dbl),  32'd31);
        check("spur_req",  32'(n_req),  32'd31);
        check("spur_zero", 32'(zero_at_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
